// File: rtl/i2s_mic_capture.sv
// I2S master receiver for an INMP441-class MEMS microphone: generates SCK/WS, deserialises SD
// MSB-first and writes each captured sample to the downstream FIFO. Define STEREO_CAPTURE_EN to capture both slots.
module i2s_mic_capture #(
  parameter int CLK_DIV      = 16,
  parameter int SLOT_BITS    = 32,
  parameter int SAMPLE_WIDTH = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable_i,
  output logic                    i2s_sck_o,
  output logic                    i2s_ws_o,
  input  logic                    i2s_sd_i,
  input  logic                    fifo_full_i,
  output logic                    wr_en_o,
  output logic [SAMPLE_WIDTH-1:0] write_data_o,
  output logic                    overflow_o,
  input  logic                    overflow_clr_i
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(SLOT_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_SAMPLE = BIT_W'(SAMPLE_WIDTH);

  logic [DIV_W-1:0]        div_cnt_reg;
  logic [BIT_W-1:0]        bit_cnt_reg;
  logic                    sck_reg;
  logic                    ws_reg;
  logic [SAMPLE_WIDTH-1:0] shift_reg;
  logic                    done_reg;
  logic                    wr_en_reg;
  logic [SAMPLE_WIDTH-1:0] write_data_reg;
  logic                    overflow_reg;
  logic                    sd_meta_reg;
  logic                    sd_sync_reg;

  logic                    div_wrap;
  logic                    rise_evt;
  logic                    fall_evt;
  logic                    bit_in_sample;
  logic                    slot_captured;
  logic                    write_go;
  logic [SAMPLE_WIDTH:0]   shift_ext;

`ifdef STEREO_CAPTURE_EN
  assign slot_captured = 1'b1;
`else
  assign slot_captured = ~ws_reg;
`endif

  assign div_wrap      = enable_i && (div_cnt_reg == DIV_LAST);
  assign rise_evt      = div_wrap && !sck_reg;
  assign fall_evt      = div_wrap && sck_reg;
  // Bit 0 of every slot is the I2S one-bit delay and carries no sample data.
  assign bit_in_sample = (bit_cnt_reg != '0) && (bit_cnt_reg <= BIT_SAMPLE);
  assign shift_ext     = {shift_reg, sd_sync_reg};
  assign write_go      = enable_i && done_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sd_meta_reg <= 1'b0;
      sd_sync_reg <= 1'b0;
    end else begin
      sd_meta_reg <= i2s_sd_i;
      sd_sync_reg <= sd_meta_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !enable_i) begin
      div_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      sck_reg     <= 1'b0;
      ws_reg      <= 1'b0;
      shift_reg   <= '0;
      done_reg    <= 1'b0;
    end else begin
      div_cnt_reg <= div_wrap ? '0 : div_cnt_reg + 1'b1;
      if (div_wrap) begin
        sck_reg <= ~sck_reg;
      end
      if (fall_evt) begin
        if (bit_cnt_reg == BIT_LAST) begin
          bit_cnt_reg <= '0;
          ws_reg      <= ~ws_reg;
        end else begin
          bit_cnt_reg <= bit_cnt_reg + 1'b1;
        end
      end
      if (rise_evt && bit_in_sample) begin
        shift_reg <= shift_ext[SAMPLE_WIDTH-1:0];
      end
      done_reg <= rise_evt && (bit_cnt_reg == BIT_SAMPLE) && slot_captured;
    end
  end

  // Write-side state survives enable_i=0 so the last sample and the drop flag stay visible.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en_reg      <= 1'b0;
      write_data_reg <= '0;
      overflow_reg   <= 1'b0;
    end else begin
      wr_en_reg <= write_go && !fifo_full_i;
      if (write_go && !fifo_full_i) begin
        write_data_reg <= shift_reg;
      end
      if (write_go && fifo_full_i) begin
        overflow_reg <= 1'b1;
      end else if (overflow_clr_i) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  assign i2s_sck_o    = sck_reg;
  assign i2s_ws_o     = ws_reg;
  assign wr_en_o      = wr_en_reg;
  assign write_data_o = write_data_reg;
  assign overflow_o   = overflow_reg;

endmodule

// File: tb/tb_i2s_mic_capture.sv
// Scoreboard bench for i2s_mic_capture (CLK_DIV=4): a mic model serialises directed words,
// expected samples are queued at stimulus time and a monitor checks every FIFO write.
module tb_i2s_mic_capture;

`ifdef STEREO_CAPTURE_EN
  localparam bit STEREO = 1'b1;
`else
  localparam bit STEREO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable_i = 1'b0;
  logic        i2s_sck_o;
  logic        i2s_ws_o;
  logic        i2s_sd_i = 1'b1;
  logic        fifo_full_i = 1'b0;
  logic        wr_en_o;
  logic [23:0] write_data_o;
  logic        overflow_o;
  logic        overflow_clr_i = 1'b0;

  i2s_mic_capture #(.CLK_DIV(4), .SLOT_BITS(32), .SAMPLE_WIDTH(24)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable_i       (enable_i),
    .i2s_sck_o      (i2s_sck_o),
    .i2s_ws_o       (i2s_ws_o),
    .i2s_sd_i       (i2s_sd_i),
    .fifo_full_i    (fifo_full_i),
    .wr_en_o        (wr_en_o),
    .write_data_o   (write_data_o),
    .overflow_o     (overflow_o),
    .overflow_clr_i (overflow_clr_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int t0 = 0;
  logic [23:0] exp_q[$];
  logic [23:0] mic_left = 24'h0;
  logic [23:0] mic_right = 24'h0;

  always @(posedge clk) cyc = cyc + 1;

  // Mic model: changes SD just after each SCK fall; bit 0 and bits past 24 are driven 1.
  int   mic_idx = 0;
  logic sck_prev = 1'b0;
  logic ws_prev = 1'b0;
  always @(posedge clk) begin
    logic [23:0] word;
    #1;
    if (!enable_i) begin
      mic_idx = 0;
    end else if (sck_prev && !i2s_sck_o) begin
      if (i2s_ws_o != ws_prev) mic_idx = 0;
      else mic_idx = mic_idx + 1;
    end
    sck_prev = i2s_sck_o;
    ws_prev  = i2s_ws_o;
    word = i2s_ws_o ? mic_right : mic_left;
    if (mic_idx >= 1 && mic_idx <= 24) i2s_sd_i = word[24-mic_idx];
    else i2s_sd_i = 1'b1;
  end

  // Monitor: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (wr_en_o === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got data 0x%06h, required no write", write_data_o);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        if (write_data_o !== e) begin
          n_fail++;
          $display("FAIL write_data: got 0x%06h required 0x%06h", write_data_o, e);
        end else begin
          $display("write 0x%06h at cycle %0d", write_data_o, cyc - t0);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end else begin
      $display("check %s = 0x%0h", name, act);
    end
  endtask

  task automatic wait_to(input int k);
    while (cyc - t0 < k) @(negedge clk);
  endtask

  task automatic start_enable();
    @(negedge clk);
    t0 = cyc;
    enable_i = 1'b1;
  endtask

  initial begin
    int first_rise;
    // Reset
    repeat (4) @(negedge clk);
    chk("rst_sck", 32'(i2s_sck_o), 32'h0);
    chk("rst_ws", 32'(i2s_ws_o), 32'h0);
    chk("rst_wr_en", 32'(wr_en_o), 32'h0);
    chk("rst_data", 32'(write_data_o), 32'h0);
    chk("rst_overflow", 32'(overflow_o), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Timing and first frames: writes at 197/709 (left), 453/965 (right, stereo only)
    mic_left  = 24'hA5A5A5;
    mic_right = 24'hFFFFFF;
    for (int f = 0; f < 2; f++) begin
      exp_q.push_back(24'hA5A5A5);
      if (STEREO) exp_q.push_back(24'hFFFFFF);
    end
    start_enable();
    first_rise = 0;
    for (int i = 0; i < 20 && !i2s_sck_o; i++) @(negedge clk);
    first_rise = cyc - t0;
    chk("first_rise_cycle", 32'(first_rise), 32'd4);
    wait_to(7);   chk("sck_high_c7", 32'(i2s_sck_o), 32'h1);
    wait_to(8);   chk("sck_fall_c8", 32'(i2s_sck_o), 32'h0);
    wait_to(12);  chk("sck_rise_c12", 32'(i2s_sck_o), 32'h1);
    wait_to(255); chk("ws_left_c255", 32'(i2s_ws_o), 32'h0);
    wait_to(256); chk("ws_right_c256", 32'(i2s_ws_o), 32'h1);
    chk("ws_on_fall_c256", 32'(i2s_sck_o), 32'h0);
    wait_to(1000);
    chk("queue_drained_a", 32'(exp_q.size()), 32'd0);
    chk("no_overflow_a", 32'(overflow_o), 32'h0);

    // FIFO full: drops at 1221 (L), 1477 (R stereo), 1733 (L)
    fifo_full_i = 1'b1;
    wait_to(1300);
    chk("overflow_set", 32'(overflow_o), 32'h1);
    overflow_clr_i = 1'b1;
    wait_to(1301);
    overflow_clr_i = 1'b0;
    chk("overflow_cleared", 32'(overflow_o), 32'h0);
    wait_to(1600);
    overflow_clr_i = 1'b1;
    wait_to(1601);
    overflow_clr_i = 1'b0;
    chk("overflow_cleared2", 32'(overflow_o), 32'h0);
    wait_to(1732);
    overflow_clr_i = 1'b1;
    wait_to(1733);
    overflow_clr_i = 1'b0;
    chk("overflow_set_wins", 32'(overflow_o), 32'h1);
    wait_to(1734);
    fifo_full_i = 1'b0;
    if (STEREO) exp_q.push_back(24'hFFFFFF);

    // Abort mid-sample at left bit_cnt=10
    wait_to(2130);
    enable_i = 1'b0;
    wait_to(2131);
    chk("abort_sck_low", 32'(i2s_sck_o), 32'h0);
    chk("abort_ws_low", 32'(i2s_ws_o), 32'h0);
    wait_to(2300);
    chk("abort_data_held", 32'(write_data_o), STEREO ? 32'hFFFFFF : 32'hA5A5A5);
    chk("abort_overflow_held", 32'(overflow_o), 32'h1);
    chk("queue_drained_b", 32'(exp_q.size()), 32'd0);

    // Re-enable: fresh frame from left slot bit 0
    mic_left  = 24'h0F0F0F;
    mic_right = 24'h800001;
    exp_q.push_back(24'h0F0F0F);
    if (STEREO) exp_q.push_back(24'h800001);
    start_enable();
    wait_to(300);
    chk("reenable_data", 32'(write_data_o), 32'h0F0F0F);
    wait_to(480);
    mic_left = 24'h123456;
    exp_q.push_back(24'h123456);
    if (STEREO) exp_q.push_back(24'h800001);
    wait_to(1000);
    chk("final_data", 32'(write_data_o), STEREO ? 32'h800001 : 32'h123456);
    chk("queue_drained_c", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
